ram_port_arbiter: RTL and testbench

Shares port A of a single-clock full dual-port RAM between `Requesters` independent clients using a round-robin valid/ready handshake. After every reset it first clears the whole RAM to zero. Read data is returned to the winning requester with fixed one-cycle latency. The block sits between client logic and the RAM instance; port B stays free for a dedicated datapath.

---
 rtl/ram_port_arbiter.sv | 119 +++++++++++
 tb/tb_ram_port_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter sharing RAM port A between clients, with post-reset clear pass
module ram_port_arbiter #(
  parameter int Width      = 32,
  parameter int Depth      = 1024,
  parameter int Requesters = 4,
  localparam int AW        = $clog2(Depth),
  localparam int RW        = $clog2(Requesters)
) (
  input  logic                       ipClk,
  input  logic                       ipReset,
  input  logic [Requesters-1:0]      ipReq_Valid,
  input  logic [Requesters*AW-1:0]   ipReq_Address,
  input  logic [Requesters*Width-1:0] ipReq_WrData,
  input  logic [Requesters-1:0]      ipReq_WrEnable,
  output logic [Requesters-1:0]      opReq_Ready,
  output logic [Requesters-1:0]      opRdValid,
  output logic [Width-1:0]           opRdData,
  output logic                       opInitDone,
  output logic                       opClkEnable,
  output logic [AW-1:0]              opAddress,
  output logic [Width-1:0]           opWrData,
  output logic                       opWrEnable,
  input  logic [Width-1:0]           ipRdData
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  // One spare bit so ptr + offset can exceed Requesters-1 before wrapping
  localparam int SW = RW + 1;
  localparam logic [SW-1:0] REQ_N = SW'(Requesters);

  logic [0:0]            r_state;
  logic [AW-1:0]         r_count;
  logic [RW-1:0]         r_ptr;
  logic                  r_init_done;
  logic [Requesters-1:0] r_rd_valid;

  logic                  w_any;
  logic [RW-1:0]         w_gnt;
  logic [SW-1:0]         w_sum;
  logic                  w_run;
  logic [Requesters-1:0] w_ready;
  logic [RW-1:0]         w_ptr_next;
  logic                  w_sel_we;

  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_sum = '0;
    for (int k = 0; k < Requesters; k++) begin
      w_sum = {1'b0, r_ptr} + SW'(k);
      if (w_sum >= REQ_N) begin
        w_sum = w_sum - REQ_N;
      end
      if (!w_any && ipReq_Valid[w_sum[RW-1:0]]) begin
        w_any = 1'b1;
        w_gnt = w_sum[RW-1:0];
      end
    end
  end

  assign w_run      = (r_state == ST_RUN) && !ipReset;
  assign w_ready    = (w_run && w_any) ? (Requesters'(1) << w_gnt) : '0;
  assign w_ptr_next = (w_gnt == RW'(Requesters - 1)) ? '0 : w_gnt + RW'(1);
  assign w_sel_we   = ipReq_WrEnable[w_gnt];

  always_comb begin
    opClkEnable = 1'b0;
    opWrEnable  = 1'b0;
    opAddress   = '0;
    opWrData    = '0;
    if (!ipReset) begin
      if (r_state == ST_CLEAR) begin
        opClkEnable = 1'b1;
        opWrEnable  = 1'b1;
        opAddress   = r_count;
      end else if (w_any) begin
        opClkEnable = 1'b1;
        opWrEnable  = w_sel_we;
        opAddress   = ipReq_Address[w_gnt*AW +: AW];
        opWrData    = ipReq_WrData[w_gnt*Width +: Width];
      end
    end
  end

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      r_state     <= ST_CLEAR;
      r_count     <= '0;
      r_ptr       <= '0;
      r_init_done <= 1'b0;
      r_rd_valid  <= '0;
    end else begin
      r_rd_valid <= '0;
      if (r_state == ST_CLEAR) begin
        if (r_count == AW'(Depth - 1)) begin
          r_state     <= ST_RUN;
          r_init_done <= 1'b1;
          r_count     <= '0;
        end else begin
          r_count <= r_count + AW'(1);
        end
      end else if (w_any) begin
        r_ptr <= w_ptr_next;
        if (!w_sel_we) begin
          r_rd_valid <= w_ready;
        end
      end
    end
  end

  // Reset gates the registered flags immediately so a pending read return is dropped
  assign opReq_Ready = w_ready;
  assign opRdValid   = ipReset ? '0 : r_rd_valid;
  assign opInitDone  = r_init_done & ~ipReset;
  assign opRdData    = ipRdData;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter with a behavioural RAM on port A
module tb_ram_port_arbiter;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int R  = 4;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [R-1:0]    req_valid, req_we, req_ready, rd_valid;
  logic [R*AW-1:0] req_addr;
  logic [R*W-1:0]  req_wdata;
  logic [W-1:0]    rd_data, ram_wdata, ram_rdata;
  logic [AW-1:0]   ram_addr;
  logic            init_done, ram_ce, ram_we;

  logic          c_valid[R];
  logic          c_we[R];
  logic [AW-1:0] c_addr[R];
  logic [W-1:0]  c_data[R];

  always_comb begin
    for (int i = 0; i < R; i++) begin
      req_valid[i]            = c_valid[i];
      req_we[i]               = c_we[i];
      req_addr[i*AW +: AW]    = c_addr[i];
      req_wdata[i*W +: W]     = c_data[i];
    end
  end

  ram_port_arbiter #(.Width(W), .Depth(D), .Requesters(R)) dut (
    .ipClk(clk), .ipReset(rst),
    .ipReq_Valid(req_valid), .ipReq_Address(req_addr),
    .ipReq_WrData(req_wdata), .ipReq_WrEnable(req_we),
    .opReq_Ready(req_ready), .opRdValid(rd_valid), .opRdData(rd_data),
    .opInitDone(init_done), .opClkEnable(ram_ce), .opAddress(ram_addr),
    .opWrData(ram_wdata), .opWrEnable(ram_we), .ipRdData(ram_rdata)
  );

  // RAM with registered address/data and unregistered output; preloaded with junk
  logic [W-1:0]  ram_mem[D];
  logic [AW-1:0] ram_raddr;
  assign ram_rdata = ram_mem[ram_raddr];
  always begin
    for (int i = 0; i < D; i++) ram_mem[i] = 32'hA5A5_0000 | i;
    ram_raddr = '0;
    forever begin
      @(posedge clk);
      if (ram_ce) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_raddr <= ram_addr;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    int           client;
    logic [W-1:0] data;
  } exp_t;

  exp_t         exp_q[$];
  int           gnt_log[$];
  logic [W-1:0] ref_mem[D];

  // Monitor: sample mid-cycle, retire last cycle's read, then record this cycle's transfer
  initial begin
    exp_t         e;
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        check("rst_rdvalid", 64'(rd_valid), 64'd0);
        exp_q.delete();
        for (int i = 0; i < D; i++) ref_mem[i] = '0;
      end else begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rd_valid", 64'(rd_valid), 64'(4'(1) << e.client));
          check("rd_data", 64'(rd_data), 64'(e.data));
        end else if (rd_valid != '0) begin
          check("spurious_rdvalid", 64'(rd_valid), 64'd0);
        end
        if (req_ready != '0)
          check("ready_onehot_valid", {62'd0, $countones(req_ready) == 1, |(req_ready & ~req_valid)}, 64'd2);
        for (int g = 0; g < R; g++) begin
          if (req_valid[g] && req_ready[g]) begin
            gnt_log.push_back(g);
            a = req_addr[g*AW +: AW];
            check("ram_addr", 64'(ram_addr), 64'(a));
            if (req_we[g]) ref_mem[a] = req_wdata[g*W +: W];
            else exp_q.push_back('{g, ref_mem[a]});
          end
        end
      end
    end
  end

  task automatic xfer(input int c, input logic we, input logic [AW-1:0] a,
                      input logic [W-1:0] d, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    c_valid[c] = 1'b1;
    c_we[c]    = we;
    c_addr[c]  = a;
    c_data[c]  = d;
    while (!done && waits < 64) begin
      #1;
      done = req_ready[c];
      @(negedge clk);
      if (!done) waits++;
    end
    if (!done) check("xfer_timeout", 64'd0, 64'd1);
    c_valid[c] = 1'b0;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!init_done && n < 64);
    check("init_cycles", 64'(n), 64'(D));
    @(negedge clk);
  endtask

  int w, w0, w1, w2, w3, cnt0, cnt2;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < R; i++) begin
      c_valid[i] = 1'b0; c_we[i] = 1'b0; c_addr[i] = '0; c_data[i] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_init", 64'(init_done), 64'd0);
    check("rst_ce", 64'(ram_ce), 64'd0);
    check("rst_we", 64'(ram_we), 64'd0);
    check("rst_addr", 64'(ram_addr), 64'd0);
    check("rst_wdata", 64'(ram_wdata), 64'd0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    check("clr_first_ce_we", {62'd0, ram_ce, ram_we}, 64'd3);
    check("clr_first_addr", 64'(ram_addr), 64'd0);
    wait_init();

    for (int a = 0; a < D; a++) xfer(0, 1'b0, AW'(a), '0, w);

    xfer(1, 1'b1, 4'd15, 32'hDEADBEEF, w);
    check("wr_ready_immediate", 64'(w), 64'd0);
    xfer(1, 1'b0, 4'd15, '0, w);
    check("rd_ready_immediate", 64'(w), 64'd0);
    #2;
    check("rd_back_valid", 64'(rd_valid), 64'h2);
    check("rd_back_data", 64'(rd_data), 64'hDEADBEEF);
    @(negedge clk);

    for (int i = 0; i < R; i++) xfer(3, 1'b1, AW'(4 + i), 32'hC0DE_0000 + i, w);
    gnt_log.delete();
    fork
      xfer(0, 1'b0, 4'd4, '0, w0);
      xfer(1, 1'b0, 4'd5, '0, w1);
      xfer(2, 1'b0, 4'd6, '0, w2);
      xfer(3, 1'b0, 4'd7, '0, w3);
    join
    check("cont_count", 64'(gnt_log.size()), 64'd4);
    for (int i = 0; i < gnt_log.size(); i++) check("cont_order", 64'(gnt_log[i]), 64'(i));

    gnt_log.delete();
    fork
      begin for (int i = 0; i < 5; i++) xfer(0, 1'b0, AW'(i), '0, w0); end
      begin for (int i = 0; i < 5; i++) xfer(2, 1'b0, AW'(8 + i), '0, w2); end
    join
    cnt0 = 0;
    cnt2 = 0;
    for (int i = 0; i < gnt_log.size(); i++) begin
      check("rr_alternate", 64'(gnt_log[i]), (i % 2 == 0) ? 64'd0 : 64'd2);
      if (gnt_log[i] == 0) cnt0++;
      if (gnt_log[i] == 2) cnt2++;
    end
    check("rr_grants_c0", 64'(cnt0), 64'd5);
    check("rr_grants_c2", 64'(cnt2), 64'd5);

    for (int i = 0; i < 5; i++) begin
      #1;
      check("idle_ready", 64'(req_ready), 64'd0);
      check("idle_ce_we", {62'd0, ram_ce, ram_we}, 64'd0);
      @(negedge clk);
    end
    gnt_log.delete();
    fork
      xfer(2, 1'b0, 4'd6, '0, w2);
      xfer(3, 1'b0, 4'd7, '0, w3);
    join
    check("idle_next_grant", 64'(gnt_log.size() > 0 ? gnt_log[0] : -1), 64'd3);

    xfer(0, 1'b0, 4'd15, '0, w);
    rst = 1'b1;
    #2;
    check("midrst_rdvalid", 64'(rd_valid), 64'd0);
    check("midrst_init", 64'(init_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_init();
    for (int a = 0; a < D; a++) xfer(1, 1'b0, AW'(a), '0, w);
    #2;
    check("post_clear_last", 64'(rd_data), 64'd0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
